// File: rtl/tmds_decoder.sv
// TMDS channel decoder: control-token word alignment with bitslip search,
// followed by a two-stage registered symbol decode (sym -> de/ctrl/data).
module tmds_decoder #(
  parameter int unsigned SEARCH_LEN = 4096,
  parameter int unsigned LOCK_RUN   = 8,
  parameter int unsigned SLIP_WAIT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym_i,
  output logic       bitslip_o,
  output logic       aligned_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CTRL_W     = 2;
  localparam int unsigned SYM_CNT_W  = $clog2(SEARCH_LEN + 1);
  localparam int unsigned RUN_CNT_W  = $clog2(LOCK_RUN + 1);
  localparam int unsigned WAIT_CNT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  localparam logic [SYM_W-1:0] TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  // Exact control-token match: returns {hit, ctrl value}.
  function automatic logic [CTRL_W:0] classify(input logic [SYM_W-1:0] s);
    logic [CTRL_W:0] r;
    r = '0;
    case (s)
      TOK_00:  r = 3'b100;
      TOK_01:  r = 3'b101;
      TOK_10:  r = 3'b110;
      TOK_11:  r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Undo the optional inversion (bit 9) and the XOR/XNOR chain (bit 8).
  function automatic logic [DATA_W-1:0] decode_data(input logic [SYM_W-1:0] s);
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] d;
    q = s[9] ? ~s[DATA_W-1:0] : s[DATA_W-1:0];
    d = '0;
    d[0] = q[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------
  // Decode pipeline
  // ---------------------------------------------------------------------
  logic [SYM_W-1:0]  sym_q;
  logic              de_q,   de_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W:0]   cls_pipe;

  // Stage 1: capture the raw symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= '0;
    end else begin
      sym_q <= sym_i;
    end
  end

  // Stage 2 next value: control tokens update ctrl, data symbols keep it.
  always_comb begin
    cls_pipe = classify(sym_q);
    de_d     = 1'b1;
    ctrl_d   = ctrl_q;
    data_d   = decode_data(sym_q);
    if (cls_pipe[CTRL_W]) begin
      de_d   = 1'b0;
      ctrl_d = cls_pipe[CTRL_W-1:0];
      data_d = '0;
    end
  end

  // Stage 2: registered decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q   <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------
  state_e                state_q,    state_d;
  logic [SYM_CNT_W-1:0]  sym_cnt_q,  sym_cnt_d;
  logic [RUN_CNT_W-1:0]  run_cnt_q,  run_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  bitslip_q;
  logic                  aligned_q;
  logic [CTRL_W:0]       cls_in;
  logic                  tok_hit;
  logic [RUN_CNT_W-1:0]  run_next;

  // Token detection on the live symbol plus the saturating run length.
  always_comb begin
    cls_in   = classify(sym_i);
    tok_hit  = cls_in[CTRL_W];
    run_next = '0;
    if (tok_hit) begin
      if (run_cnt_q == RUN_CNT_W'(LOCK_RUN)) begin
        run_next = run_cnt_q;
      end else begin
        run_next = run_cnt_q + RUN_CNT_W'(1);
      end
    end
  end

  // Next state and counters; lock beats search timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    run_cnt_d  = run_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      SEARCH: begin
        run_cnt_d = run_next;
        if (run_next == RUN_CNT_W'(LOCK_RUN)) begin
          state_d   = LOCKED;
          sym_cnt_d = '0;
        end else if (sym_cnt_q == SYM_CNT_W'(SEARCH_LEN - 1)) begin
          state_d   = SLIP;
          sym_cnt_d = '0;
          run_cnt_d = '0;
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
        end
      end
      SLIP: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        // Settle window spans wait_cnt = 0..SLIP_WAIT; nothing else counts here.
        if (wait_cnt_q == WAIT_CNT_W'(SLIP_WAIT)) begin
          state_d    = SEARCH;
          wait_cnt_d = '0;
          sym_cnt_d  = '0;
          run_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      LOCKED: begin
        run_cnt_d = run_next;
        if (tok_hit) begin
          sym_cnt_d = '0;
        end else if (sym_cnt_q == SYM_CNT_W'(SEARCH_LEN - 1)) begin
          state_d   = SEARCH;
          sym_cnt_d = '0;
          run_cnt_d = '0;
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
        end
      end
      default: begin
        state_d    = SEARCH;
        sym_cnt_d  = '0;
        run_cnt_d  = '0;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      sym_cnt_q  <= '0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      bitslip_q  <= (state_d == SLIP);
      aligned_q  <= (state_q == LOCKED);
    end
  end

  assign bitslip_o = bitslip_q;
  assign aligned_o = aligned_q;
  assign de_o      = de_q;
  assign ctrl_o    = ctrl_q;
  assign data_o    = data_q;

endmodule
